mem_arbiter: RTL and testbench
==============================

// Module: mem_arbiter
// PURPOSE
//  Shares the single byte-wide RAM port between instruction fetch (IF) and the
//  load/store stage (MEM). Serialises each 1/2/4-byte access into per-byte RAM
//  cycles and returns a one-cycle done pulse. The stall controller derives
//  if_stall/mem_stall from (req && !done). Sits between the IF/MEM stages and the
//  RAM.
// PARAMETERS
//  ADDR_W   32  address width of the request and RAM ports
// PORTS
//  clk        in   1   system clock; all state updates on the rising edge
//  rst        in   1   synchronous, active-low reset (rst==0 resets on clk edge)
//  rdy        in   1   global enable; 0 freezes all state
//  if_req     in   1   fetch request; held until if_done; may drop to abort
//  if_addr    in   32  fetch address (always a 4-byte read)
//  if_done    out  1   one-cycle pulse: if_data valid
//  if_data    out  32  fetched word, little-endian
//  mem_req    in   1   load/store request; held until mem_done; never aborted
//  mem_we     in   1   1=store, 0=load
//  mem_len    in   2   00=byte, 01=half, 10=word (11 treated as word)
//  mem_addr   in   32  access start address
//  mem_wdata  in   32  store data; low bytes used first
//  mem_done   out  1   one-cycle pulse: access complete, mem_rdata valid on load
//  mem_rdata  out  32  load data, zero-extended above mem_len
//  ram_din    in   8   RAM read data; valid 1 cycle after ram_a is presented
//  ram_dout   out  8   RAM write data
//  ram_a      out  32  RAM byte address
//  ram_wr     out  1   1=write ram_dout to ram_a this cycle
// BEHAVIOUR
//  - Reset: state IDLE; if_done, mem_done, ram_wr = 0; ram_a, ram_dout,
//    if_data, mem_rdata = 0; byte counter = 0.
//  - FSM states: IDLE, IF_RD, MEM_RD, MEM_WR.
//  - IDLE: if mem_req -> MEM_RD/MEM_WR (MEM has priority); else if if_req ->
//    IF_RD. Requests are latched (addr, len, wdata) in the grant cycle.
//  - Read of N bytes (request seen at cycle 0): ram_a = addr+k on cycles 1..N;
//    byte k is captured from ram_din on cycle k+2 into bits [8k+7:8k]. The done
//    pulse and data appear on cycle N+2. A word fetch therefore completes at cycle 6.
//  - Write of N bytes: ram_wr = 1, ram_a = addr+k, ram_dout = wdata[8k+7:8k] on
//    cycles 1..N. mem_done is asserted on cycle N+1. ram_wr is 0 in every other
//    cycle.
//  - Done cycle: state is IDLE, but requests are ignored for that one cycle
//    (turnaround). The earliest next grant is done+1, so a held request is never
//    granted twice.
//  - ram_a holds its last value when idle. Address arithmetic wraps modulo 2^ADDR_W.
//  - IF abort: if_req == 0 in any IF_RD cycle -> IDLE on the next edge, no
//    if_done, partial data discarded. A pending mem_req may be granted from IDLE
//    on the following cycle.
//  - Simultaneous mem_req and if_req in IDLE: MEM granted. IF waits and is
//    granted at mem_done+1 if it is still requesting.
//  - rdy == 0: no register updates (FSM, counter, captured bytes frozen).
//    ram_wr, if_done and mem_done are forced to 0 at the outputs. Operation resumes
//    exactly where it stopped when rdy returns to 1. A pending done is then
//    presented. A read byte whose ram_din arrival falls in an rdy==0 cycle is
//    re-requested (ram_a re-presented) on resume.
//  - Reset mid-transaction: abandon immediately, no done, outputs to reset values.
// TESTING
//  1. Fetch: if_req=1, if_addr=0x100, RAM[0x100..0x103] = 13 05 00 00
//     -> ram_a 0x100..0x103 on cycles 1-4; if_done on cycle 6;
//     if_data=0x00000513.
//  2. Store word: mem_we=1, len=10, addr=0x2000, wdata=0xDEADBEEF
//     -> ram_wr=1 with EF,BE,AD,DE at 0x2000..0x2003 on cycles 1-4;
//     mem_done on cycle 5.
//  3. Load half: len=01, addr=0x31, RAM[0x31]=0x34, RAM[0x32]=0x12
//     -> mem_done on cycle 4; mem_rdata=0x00001234.
//  4. if_req and mem_req both raised on cycle 0 (load byte 0x40)
//     -> MEM granted first, mem_done on cycle 3; IF granted on cycle 4,
//     if_done on cycle 10.
//  5. Fetch aborted (if_req drops on cycle 2) -> no if_done; IDLE on cycle 3;
//     a new if_req on cycle 3 fetches a fresh word correctly.
//  6. rdy=0 for cycles 2-4 during a word store -> no ram_wr in those cycles;
//     all 4 bytes written exactly once; mem_done on cycle 8. Also: rst=0 on
//     cycle 2 of a fetch -> no done, all outputs 0.

Source files
------------

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Purpose  : Shares one byte-wide RAM port between instruction fetch (IF) and
//            the load/store stage (MEM). Each 1/2/4-byte access is broken into
//            per-byte RAM cycles and finished with a one-cycle done pulse.
// Revision : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_done,
    output logic [31:0]       if_data,
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [1:0]        mem_len,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [31:0]       mem_wdata,
    output logic              mem_done,
    output logic [31:0]       mem_rdata,
    input  logic [7:0]        ram_din,
    output logic [7:0]        ram_dout,
    output logic [ADDR_W-1:0] ram_a,
    output logic              ram_wr
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        IF_RD  = 2'd1,
        MEM_RD = 2'd2,
        MEM_WR = 2'd3
    } state_t;

    state_t            state;
    state_t            state_n;

    // Latched request and datapath registers
    logic [ADDR_W-1:0] base_addr;
    logic [31:0]       wdata_q;
    logic [1:0]        last_idx;     // index of the final byte (N-1)
    logic [1:0]        cnt;          // byte index currently driven on ram_a_q
    logic [1:0]        cap;          // byte index expected next on ram_din
    logic [31:0]       data_q;       // bytes captured so far
    logic [ADDR_W-1:0] ram_a_q;
    logic [7:0]        ram_dout_q;
    logic              ram_wr_q;
    logic              if_done_q;
    logic              mem_done_q;

    // Tracks which byte index the RAM saw last cycle; it follows the RAM's
    // one-cycle read latency, which keeps running while rdy is low.
    logic              prev_vld;
    logic [1:0]        prev_idx;

    // Control strobes
    logic              is_rd;
    logic              din_hit;
    logic              capture;
    logic              redo;
    logic              grant_mem;
    logic              grant_if;
    logic              step;
    logic              finish;
    logic              busy_done;
    logic [1:0]        next_idx;
    logic [1:0]        grant_last;
    logic [31:0]       assembled;

    assign is_rd     = (state == IF_RD) || (state == MEM_RD);
    assign din_hit   = prev_vld && (prev_idx == cap);
    assign capture   = rdy && is_rd && din_hit;
    // The byte we are waiting for was read while frozen: ask for it again.
    assign redo      = rdy && is_rd && !din_hit && (cap != cnt);
    assign busy_done = if_done_q || mem_done_q;
    assign next_idx  = cnt + 2'd1;

    assign grant_last = grant_if ? 2'd3 :
                        (mem_len == 2'b00) ? 2'd0 :
                        (mem_len == 2'b01) ? 2'd1 : 2'd3;

    assign ram_a    = redo ? (base_addr + ADDR_W'(cap)) : ram_a_q;
    assign ram_dout = ram_dout_q;
    assign ram_wr   = ram_wr_q && rdy;
    assign if_done  = if_done_q && rdy;
    assign mem_done = mem_done_q && rdy;

    // Merge the byte arriving on ram_din into the partially captured word
    always_comb begin
        assembled = data_q;
        assembled[{cap, 3'b000} +: 8] = ram_din;
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else if (rdy) begin
            state <= state_n;
        end
    end

    // Next-state logic and per-cycle control strobes
    always_comb begin
        state_n   = state;
        grant_mem = 1'b0;
        grant_if  = 1'b0;
        step      = 1'b0;
        finish    = 1'b0;
        case (state)
            IDLE: begin
                // A done cycle is a turnaround: requests are not looked at.
                if (!busy_done) begin
                    if (mem_req) begin
                        grant_mem = 1'b1;
                        state_n   = mem_we ? MEM_WR : MEM_RD;
                    end else if (if_req) begin
                        grant_if  = 1'b1;
                        state_n   = IF_RD;
                    end
                end
            end
            IF_RD, MEM_RD: begin
                if ((state == IF_RD) && !if_req) begin
                    state_n = IDLE;
                end else if (capture && (cap == last_idx)) begin
                    finish  = 1'b1;
                    state_n = IDLE;
                end else if (!redo && (cnt != last_idx)) begin
                    step = 1'b1;
                end
            end
            MEM_WR: begin
                if (cnt == last_idx) begin
                    finish  = 1'b1;
                    state_n = IDLE;
                end else begin
                    step = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Datapath: request latching, address/data sequencing, capture, done
    always_ff @(posedge clk) begin
        if (!rst) begin
            base_addr  <= '0;
            wdata_q    <= '0;
            last_idx   <= '0;
            cnt        <= '0;
            cap        <= '0;
            data_q     <= '0;
            ram_a_q    <= '0;
            ram_dout_q <= '0;
            ram_wr_q   <= 1'b0;
            if_done_q  <= 1'b0;
            mem_done_q <= 1'b0;
            if_data    <= '0;
            mem_rdata  <= '0;
            prev_vld   <= 1'b0;
            prev_idx   <= '0;
        end else begin
            prev_vld <= is_rd;
            prev_idx <= redo ? cap : cnt;
            if (rdy) begin
                if_done_q  <= 1'b0;
                mem_done_q <= 1'b0;
                if (grant_mem || grant_if) begin
                    base_addr <= grant_mem ? mem_addr : if_addr;
                    ram_a_q   <= grant_mem ? mem_addr : if_addr;
                    wdata_q   <= mem_wdata;
                    last_idx  <= grant_last;
                    cnt       <= '0;
                    cap       <= '0;
                    data_q    <= '0;
                    if (grant_mem && mem_we) begin
                        ram_wr_q   <= 1'b1;
                        ram_dout_q <= mem_wdata[7:0];
                    end
                end
                if (capture) begin
                    data_q[{cap, 3'b000} +: 8] <= ram_din;
                    cap <= cap + 2'd1;
                end
                if (step) begin
                    cnt     <= next_idx;
                    ram_a_q <= base_addr + ADDR_W'(next_idx);
                    if (state == MEM_WR) begin
                        ram_dout_q <= wdata_q[{next_idx, 3'b000} +: 8];
                    end
                end
                if (finish) begin
                    ram_wr_q <= 1'b0;
                    if (state == IF_RD) begin
                        if_done_q <= 1'b1;
                        if_data   <= assembled;
                    end else begin
                        mem_done_q <= 1'b1;
                        if (state == MEM_RD) begin
                            mem_rdata <= assembled;
                        end
                    end
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_arbiter
// Purpose  : Self-checking bench for mem_arbiter with a byte RAM model.
//            Table-driven single transactions plus hand-written sequences
//            for arbitration, abort, freeze and reset.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

    logic        clk;
    logic        rst;
    logic        rdy;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_done;
    logic [31:0] if_data;
    logic        mem_req;
    logic        mem_we;
    logic [1:0]  mem_len;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_done;
    logic [31:0] mem_rdata;
    logic [7:0]  ram_din;
    logic [7:0]  ram_dout;
    logic [31:0] ram_a;
    logic        ram_wr;

    int n_checks;
    int n_fail;

    mem_arbiter #(.ADDR_W(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .rdy       (rdy),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_done   (if_done),
        .if_data   (if_data),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_len   (mem_len),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_done  (mem_done),
        .mem_rdata (mem_rdata),
        .ram_din   (ram_din),
        .ram_dout  (ram_dout),
        .ram_a     (ram_a),
        .ram_wr    (ram_wr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Byte RAM: synchronous read (data one cycle after address), write on ram_wr
    logic [7:0]  ram [0:65535];
    logic        pk_en;
    logic [15:0] pk_a;
    logic [7:0]  pk_d;

    always @(posedge clk) begin
        if (pk_en) ram[pk_a] <= pk_d;
        else if (ram_wr) ram[ram_a[15:0]] <= ram_dout;
        ram_din <= ram[ram_a[15:0]];
    end

    typedef struct {
        logic        is_if;
        logic        we;
        logic [1:0]  len;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          exp_cyc;
        logic [31:0] exp_data;
    } vec_t;

    vec_t vecs [0:12];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic poke(input logic [15:0] a, input logic [7:0] d);
        pk_en = 1'b1;
        pk_a  = a;
        pk_d  = d;
        next_cycle();
        pk_en = 1'b0;
    endtask

    // One transaction from the table; cycle 0 is the cycle the request appears.
    task automatic run_vec(input int idx, input vec_t v);
        int          n;
        int          done_c;
        int          wr_cnt;
        int          other;
        logic [31:0] got;
        logic [31:0] wb;
        logic        is_st;
        n      = v.is_if ? 4 : ((v.len == 2'b00) ? 1 : ((v.len == 2'b01) ? 2 : 4));
        is_st  = !v.is_if && v.we;
        done_c = -1;
        wr_cnt = 0;
        other  = 0;
        got    = '0;
        if (v.is_if) begin
            if_req  = 1'b1;
            if_addr = v.addr;
        end else begin
            mem_req   = 1'b1;
            mem_we    = v.we;
            mem_len   = v.len;
            mem_addr  = v.addr;
            mem_wdata = v.wdata;
        end
        for (int c = 0; c < 20 && done_c < 0; c++) begin
            @(negedge clk);
            if (ram_wr) wr_cnt++;
            if (c >= 1 && c <= n) begin
                chk($sformatf("v%0d ram_a c%0d", idx, c), ram_a, v.addr + 32'(c - 1));
                if (is_st) begin
                    wb = v.wdata >> (8 * (c - 1));
                    chk($sformatf("v%0d ram_dout c%0d", idx, c), {24'd0, ram_dout}, {24'd0, wb[7:0]});
                end
            end
            if (v.is_if ? mem_done : if_done) other++;
            if (v.is_if ? if_done : mem_done) begin
                done_c = c;
                got    = v.is_if ? if_data : mem_rdata;
            end
            next_cycle();
        end
        if_req  = 1'b0;
        mem_req = 1'b0;
        next_cycle();
        chk($sformatf("v%0d done cycle", idx), 32'(done_c), 32'(v.exp_cyc));
        chk($sformatf("v%0d ram_wr cycles", idx), 32'(wr_cnt), is_st ? 32'(n) : 32'd0);
        chk($sformatf("v%0d stray done", idx), 32'(other), 32'd0);
        if (!is_st) chk($sformatf("v%0d data", idx), got, v.exp_data);
    endtask

    initial begin
        int          mc, ic, wr_cnt, pulses;
        logic [31:0] md, id, wr_mask, wd;

        n_checks = 0;
        n_fail   = 0;
        rst = 1'b0; rdy = 1'b1;
        if_req = 1'b0; if_addr = '0;
        mem_req = 1'b0; mem_we = 1'b0; mem_len = '0; mem_addr = '0; mem_wdata = '0;
        pk_en = 1'b0; pk_a = '0; pk_d = '0;

        //          is_if we   len    addr           wdata          cyc data
        vecs[0]  = '{1'b1, 1'b0, 2'b10, 32'h0000_0100, 32'h0,         6, 32'h0000_0513};
        vecs[1]  = '{1'b0, 1'b1, 2'b10, 32'h0000_2000, 32'hDEAD_BEEF, 5, 32'h0};
        vecs[2]  = '{1'b0, 1'b0, 2'b10, 32'h0000_2000, 32'h0,         6, 32'hDEAD_BEEF};
        vecs[3]  = '{1'b0, 1'b0, 2'b01, 32'h0000_0031, 32'h0,         4, 32'h0000_1234};
        vecs[4]  = '{1'b0, 1'b0, 2'b00, 32'h0000_0040, 32'h0,         3, 32'h0000_00A5};
        vecs[5]  = '{1'b0, 1'b1, 2'b00, 32'h0000_0050, 32'h1122_3344, 2, 32'h0};
        vecs[6]  = '{1'b0, 1'b0, 2'b10, 32'h0000_0050, 32'h0,         6, 32'h7777_7744};
        vecs[7]  = '{1'b0, 1'b1, 2'b01, 32'h0000_0060, 32'hCAFE_F00D, 3, 32'h0};
        vecs[8]  = '{1'b0, 1'b0, 2'b10, 32'h0000_0060, 32'h0,         6, 32'h9999_F00D};
        vecs[9]  = '{1'b0, 1'b0, 2'b11, 32'h0000_0030, 32'h0,         6, 32'h7812_3456};
        vecs[10] = '{1'b1, 1'b0, 2'b10, 32'hFFFF_FFFE, 32'h0,         6, 32'h0403_0201};
        vecs[11] = '{1'b0, 1'b0, 2'b00, 32'h0000_0100, 32'h0,         3, 32'h0000_0013};
        vecs[12] = '{1'b0, 1'b0, 2'b01, 32'hFFFF_FFFF, 32'h0,         4, 32'h0000_0302};

        // RAM preload while the DUT is held in reset
        next_cycle();
        poke(16'h0100, 8'h13); poke(16'h0101, 8'h05); poke(16'h0102, 8'h00); poke(16'h0103, 8'h00);
        poke(16'h0030, 8'h56); poke(16'h0031, 8'h34); poke(16'h0032, 8'h12); poke(16'h0033, 8'h78);
        poke(16'h0034, 8'h00); poke(16'h0040, 8'hA5);
        poke(16'h0050, 8'hEE); poke(16'h0051, 8'h77); poke(16'h0052, 8'h77); poke(16'h0053, 8'h77);
        poke(16'h0060, 8'hEE); poke(16'h0061, 8'hEE); poke(16'h0062, 8'h99); poke(16'h0063, 8'h99);
        poke(16'hFFFE, 8'h01); poke(16'hFFFF, 8'h02); poke(16'h0000, 8'h03); poke(16'h0001, 8'h04);
        poke(16'h2000, 8'h00); poke(16'h2001, 8'h00); poke(16'h2002, 8'h00); poke(16'h2003, 8'h00);

        // Reset values
        @(negedge clk);
        chk("reset if_done",   {31'd0, if_done},  32'd0);
        chk("reset mem_done",  {31'd0, mem_done}, 32'd0);
        chk("reset ram_wr",    {31'd0, ram_wr},   32'd0);
        chk("reset ram_a",     ram_a,             32'd0);
        chk("reset ram_dout",  {24'd0, ram_dout}, 32'd0);
        chk("reset if_data",   if_data,           32'd0);
        chk("reset mem_rdata", mem_rdata,         32'd0);
        next_cycle();
        rst = 1'b1;
        next_cycle();

        for (int i = 0; i <= 12; i++) run_vec(i, vecs[i]);

        // Simultaneous requests: MEM first, IF after the turnaround
        mc = -1; ic = -1; md = '0; id = '0;
        if_req = 1'b1; if_addr = 32'h100;
        mem_req = 1'b1; mem_we = 1'b0; mem_len = 2'b00; mem_addr = 32'h40;
        for (int c = 0; c < 30 && ic < 0; c++) begin
            if (mc >= 0) mem_req = 1'b0;
            @(negedge clk);
            if (mem_done) begin mc = c; md = mem_rdata; end
            if (if_done)  begin ic = c; id = if_data; end
            next_cycle();
        end
        if_req = 1'b0; mem_req = 1'b0;
        next_cycle();
        chk("both mem_done cycle", 32'(mc), 32'd3);
        chk("both mem_rdata",      md,      32'h0000_00A5);
        chk("both if_done cycle",  32'(ic), 32'd10);
        chk("both if_data",        id,      32'h0000_0513);

        // Fetch abort on cycle 2, fresh fetch requested on cycle 3
        ic = -1; id = '0;
        for (int c = 0; c < 30 && ic < 0; c++) begin
            if (c == 0) begin if_req = 1'b1; if_addr = 32'h100; end
            if (c == 2) if_req = 1'b0;
            if (c == 3) begin if_req = 1'b1; if_addr = 32'h31; end
            @(negedge clk);
            if (if_done) begin ic = c; id = if_data; end
            next_cycle();
        end
        if_req = 1'b0;
        next_cycle();
        chk("abort if_done cycle", 32'(ic), 32'd9);
        chk("abort if_data",       id,      32'h0078_1234);

        // Word store frozen on cycles 2-4
        mc = -1; wr_cnt = 0; wr_mask = '0;
        mem_req = 1'b1; mem_we = 1'b1; mem_len = 2'b10; mem_addr = 32'h3000; mem_wdata = 32'h0102_0304;
        for (int c = 0; c < 30 && mc < 0; c++) begin
            rdy = !(c >= 2 && c <= 4);
            @(negedge clk);
            if (ram_wr) begin
                wr_mask = wr_mask | (32'd1 << c);
                if (wr_cnt < 4) begin
                    wd = 32'h0102_0304 >> (8 * wr_cnt);
                    chk($sformatf("freeze wr addr %0d", wr_cnt), ram_a, 32'h3000 + 32'(wr_cnt));
                    chk($sformatf("freeze wr data %0d", wr_cnt), {24'd0, ram_dout}, {24'd0, wd[7:0]});
                end
                wr_cnt++;
            end
            if (mem_done) mc = c;
            next_cycle();
        end
        rdy = 1'b1; mem_req = 1'b0; mem_we = 1'b0;
        next_cycle();
        chk("freeze wr count",      32'(wr_cnt), 32'd4);
        chk("freeze wr cycles",     wr_mask,     32'h0000_00E2);
        chk("freeze mem_done cycle", 32'(mc),    32'd8);

        // Fetch frozen on cycles 3-4: lost byte is re-requested
        ic = -1; id = '0;
        if_req = 1'b1; if_addr = 32'h100;
        for (int c = 0; c < 30 && ic < 0; c++) begin
            rdy = !(c >= 3 && c <= 4);
            @(negedge clk);
            if (if_done) begin ic = c; id = if_data; end
            next_cycle();
        end
        rdy = 1'b1; if_req = 1'b0;
        next_cycle();
        chk("rdfreeze if_done cycle", 32'(ic), 32'd9);
        chk("rdfreeze if_data",       id,      32'h0000_0513);

        // Freeze on the done cycle: done is held and shown once on resume
        mc = -1; pulses = 0;
        mem_req = 1'b1; mem_we = 1'b0; mem_len = 2'b00; mem_addr = 32'h40;
        for (int c = 0; c < 8; c++) begin
            rdy = (c != 3);
            if (mc >= 0) mem_req = 1'b0;
            @(negedge clk);
            if (mem_done) begin
                pulses++;
                if (mc < 0) mc = c;
            end
            next_cycle();
        end
        rdy = 1'b1; mem_req = 1'b0;
        next_cycle();
        chk("pend mem_done cycle", 32'(mc),     32'd4);
        chk("pend mem_done count", 32'(pulses), 32'd1);

        // Reset in the middle of a fetch
        if_req = 1'b1; if_addr = 32'h100;
        for (int c = 0; c < 3; c++) begin
            if (c == 2) rst = 1'b0;
            next_cycle();
        end
        if_req = 1'b0;
        @(negedge clk);
        chk("midrst if_done",   {31'd0, if_done},  32'd0);
        chk("midrst mem_done",  {31'd0, mem_done}, 32'd0);
        chk("midrst ram_wr",    {31'd0, ram_wr},   32'd0);
        chk("midrst ram_a",     ram_a,             32'd0);
        chk("midrst ram_dout",  {24'd0, ram_dout}, 32'd0);
        chk("midrst if_data",   if_data,           32'd0);
        chk("midrst mem_rdata", mem_rdata,         32'd0);
        next_cycle();
        rst = 1'b1;
        pulses = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (if_done || mem_done) pulses++;
            next_cycle();
        end
        chk("midrst no done", 32'(pulses), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
